host_rd_master: RTL and testbench
=================================

Name: host_rd_master

Overview:
- Host-side initiator for the CPU read-request service.
- Accepts a read command (address, word count) and encodes it into one request word.
- Pushes the request word into the request FIFO that the CPU dequeues.
- Collects the CPU's read data from the read FIFO that the CPU fills, forwarding each word to a downstream consumer under valid/ready. One request is outstanding at a time.

Parameters:
- DATA_WIDTH, 32, width of the FIFO words and response data (matches the CPU data width).
- ADDR_W, 24, address field width; must be ≤ DATA_WIDTH-LEN_W.
- LEN_W, 8, word-count field width.
- MAX_WORDS, 8, largest legal cmd_len.
- TIMEOUT, 256, idle cycles allowed between response words before abort.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  LEN_W  number of words, 1..MAX_WORDS.
- req_fifo_data_in  out  DATA_WIDTH  encoded request word.
- req_fifo_enq  out  1  write strobe to the request FIFO.
- req_fifo_wrfull  in  1  request FIFO full.
- read_fifo_data_out  in  DATA_WIDTH  show-ahead head of the read FIFO; valid while !read_fifo_rdempty.
- read_fifo_deq  out  1  pop the read FIFO head.
- read_fifo_rdempty  in  1  read FIFO empty.
- rsp_data  out  DATA_WIDTH  response word.
- rsp_valid  out  1  rsp_data valid.
- rsp_ready  in  1  consumer accepts.
- rsp_last  out  1  marks the final word of a command.
- done  out  1  one-cycle pulse: command completed.
- err  out  1  one-cycle pulse: illegal length, timeout, or stray word.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE.
  - req_fifo_enq=0, done=0, err=0.
  - Internal counters cleared.
  - Reset mid-command abandons the command. Words the CPU has already enqueued are dropped afterwards as stray words (see IDLE).
- Request encoding: req_fifo_data_in = {zeros, cmd_len[LEN_W-1:0], cmd_addr[ADDR_W-1:0]}, with address in the LSBs and length directly above it.
- IDLE:
  - cmd_ready = !read_fifo_rdempty ? 0 : 1.
  - Stray-word drain: if !read_fifo_rdempty, assert read_fifo_deq for that word and pulse err the next cycle. Commands are blocked until the read FIFO is empty.
  - On command accept with cmd_len==0 or cmd_len>MAX_WORDS: pulse err the next cycle, stay in IDLE, no enq.
  - On command accept with a legal cmd_len: latch addr and len, set remaining=cmd_len, go to PUSH.
- PUSH:
  - req_fifo_enq = !req_fifo_wrfull; data is the latched encoding.
  - The cycle the enq fires, go to COLLECT and clear the timeout counter.
  - Wait indefinitely while wrfull; no timeout applies in PUSH.
- COLLECT:
  - Combinational pass-through, zero latency:
    - rsp_valid = !read_fifo_rdempty.
    - rsp_data = read_fifo_data_out.
    - rsp_last = rsp_valid && remaining==1.
    - read_fifo_deq = rsp_valid && rsp_ready.
  - Each deq decrements remaining and clears the timeout counter. Otherwise the counter increments.
  - Deq with remaining==1: go to IDLE and pulse done the next cycle.
  - Timeout counter reaching TIMEOUT-1 with no deq: pulse err, go to IDLE. Late words are then drained as strays.
  - Simultaneous deq and timeout: the deq wins and the counter clears.
- Outside COLLECT: rsp_valid=0 and rsp_last=0.
- Consumer backpressure: rsp_ready=0 holds the FIFO head and counts toward timeout. The consumer must keep rsp_ready asserted often enough.
- done and err are registered, never both high in the same cycle, and never longer than one cycle.
- Counters:
  - remaining is LEN_W bits and never wraps (cannot go below 1 in COLLECT).
  - The timeout counter is $clog2(TIMEOUT) bits and saturates.

Test Plan:
- Basic read: cmd addr=0x10, len=4; CPU returns 0xA0..0xA3 → exactly one enq with data 0x0400_0010; four rsp words in order; rsp_last only on 0xA3; done pulses once; busy falls.
- Backpressure: len=3, rsp_ready toggling 1,0,0,1 → no word lost or duplicated; deq only on rsp_valid&&rsp_ready; done after the third acceptance.
- Request FIFO full: wrfull held for 5 cycles after accept → enq stays 0 for those cycles, fires on the first !wrfull cycle, single enq total.
- Illegal length: cmd_len=0, then cmd_len=9 → err pulses twice, no enq, busy stays 0, cmd_ready remains 1.
- Timeout and stray drain: len=2, CPU sends one word and then stalls for TIMEOUT cycles → err pulses, no done. A late second word arriving in IDLE is deq'd and causes a second err pulse; cmd_ready stays 0 until the read FIFO is empty.
- Reset mid-COLLECT: assert rst after 1 of 4 words → all outputs take reset values next cycle. The following command of len=1 completes normally once the three stray words are drained, with 3 err pulses.

Source files
------------

// File: rtl/host_rd_master_if.sv
// Signal bundle between the host read master and its request FIFO, read FIFO,
// command source and response consumer.
interface host_rd_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [LEN_W-1:0]      cmd_len;

    logic [DATA_WIDTH-1:0] req_fifo_data_in;
    logic                  req_fifo_enq;
    logic                  req_fifo_wrfull;

    logic [DATA_WIDTH-1:0] read_fifo_data_out;
    logic                  read_fifo_deq;
    logic                  read_fifo_rdempty;

    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_last;

    logic                  done;
    logic                  err;
    logic                  busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        input  req_fifo_wrfull,
        input  read_fifo_data_out, read_fifo_rdempty,
        input  rsp_ready,
        output cmd_ready,
        output req_fifo_data_in, req_fifo_enq,
        output read_fifo_deq,
        output rsp_data, rsp_valid, rsp_last,
        output done, err, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        output req_fifo_wrfull,
        output read_fifo_data_out, read_fifo_rdempty,
        output rsp_ready,
        input  cmd_ready,
        input  req_fifo_data_in, req_fifo_enq,
        input  read_fifo_deq,
        input  rsp_data, rsp_valid, rsp_last,
        input  done, err, busy
    );
endinterface

// File: rtl/host_rd_master.sv
// Host read initiator: encodes one read command into a request word, then
// streams the returned words to the consumer, one command outstanding at a time.
module host_rd_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 8,
    parameter int MAX_WORDS  = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic clk,
    input  logic rst,
    host_rd_master_if.master bus
);
    localparam int TCNT_W = $clog2(TIMEOUT);
    localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_WORDS);
    localparam logic [LEN_W-1:0]  ONE      = LEN_W'(1);
    localparam logic [TCNT_W-1:0] TCNT_END = TCNT_W'(TIMEOUT - 1);
    localparam logic [TCNT_W-1:0] TCNT_SAT = {TCNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, PUSH, COLLECT} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [LEN_W-1:0]  len_q, len_next;
    logic [LEN_W-1:0]  remaining, remaining_next;
    logic [TCNT_W-1:0] tcnt, tcnt_next;
    logic              done_q, done_next;
    logic              err_q, err_next;
    logic              cmd_ready;
    logic              enq, deq, rsp_valid, rsp_last;

    assign cmd_ready = (state == IDLE) && bus.read_fifo_rdempty;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a variable unassigned (no latch inferred).
        state_next     = state;
        addr_next      = addr_q;
        len_next       = len_q;
        remaining_next = remaining;
        tcnt_next      = tcnt;
        done_next      = 1'b0;
        err_next       = 1'b0;
        enq            = 1'b0;
        deq            = 1'b0;
        rsp_valid      = 1'b0;
        rsp_last       = 1'b0;

        case (state)
            IDLE: begin
                if (!bus.read_fifo_rdempty) begin
                    // Word with no command behind it: drop it and flag it.
                    deq      = 1'b1;
                    err_next = 1'b1;
                end else if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0 || bus.cmd_len > MAX_LEN) begin
                        err_next = 1'b1;
                    end else begin
                        addr_next      = bus.cmd_addr;
                        len_next       = bus.cmd_len;
                        remaining_next = bus.cmd_len;
                        state_next     = PUSH;
                    end
                end
            end
            PUSH: begin
                if (!bus.req_fifo_wrfull) begin
                    enq        = 1'b1;
                    tcnt_next  = '0;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                rsp_valid = !bus.read_fifo_rdempty;
                rsp_last  = rsp_valid && (remaining == ONE);
                deq       = rsp_valid && bus.rsp_ready;
                if (deq) begin
                    tcnt_next = '0;
                    if (remaining == ONE) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        remaining_next = remaining - ONE;
                    end
                end else if (tcnt == TCNT_END) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (tcnt != TCNT_SAT) begin
                    tcnt_next = tcnt + TCNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            tcnt      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            tcnt      <= tcnt_next;
            done_q    <= done_next;
            err_q     <= err_next;
        end
    end

    // NOTE: the latched command is pure datapath, only read after it has been
    // loaded in IDLE, so it carries no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_next;
        len_q  <= len_next;
    end

    assign bus.cmd_ready        = cmd_ready;
    assign bus.req_fifo_data_in = DATA_WIDTH'({len_q, addr_q});
    assign bus.req_fifo_enq     = enq;
    assign bus.read_fifo_deq    = deq;
    assign bus.rsp_data         = bus.read_fifo_data_out;
    assign bus.rsp_valid        = rsp_valid;
    assign bus.rsp_last         = rsp_last;
    assign bus.done             = done_q;
    assign bus.err              = err_q;
    assign bus.busy             = (state != IDLE);
endmodule

// File: tb/tb_host_rd_master.sv
// Directed bench for host_rd_master: models the CPU FIFOs and the consumer,
// and checks handshakes, ordering, timing and error pulses.
module tb_host_rd_master;
    localparam int DW   = 32;
    localparam int AW   = 24;
    localparam int LW   = 8;
    localparam int MAXW = 8;
    localparam int TO   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    host_rd_master_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .LEN_W(LW)) bus ();

    host_rd_master #(
        .DATA_WIDTH(DW), .ADDR_W(AW), .LEN_W(LW), .MAX_WORDS(MAXW), .TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // CPU-side FIFO model, consumer model and event log
    logic [31:0] rq[$];
    logic [31:0] pending[$];
    logic [31:0] got_data[$];
    bit          got_last[$];
    bit          rdy_pat[$];
    bit          rdy_default = 1'b1;
    int          wrfull_cnt  = 0;

    int cyc = 0;
    int enq_cnt, done_cnt, err_cnt, stray_cnt;
    int acc_cyc, enq_cyc, last_deq_cyc, err_cyc, done_cyc;
    logic [31:0] last_enq_data;
    int deq_bad = 0, enq_bad = 0, both_cnt = 0, rdy_bad = 0;

    task automatic clear_stats();
        enq_cnt = 0; done_cnt = 0; err_cnt = 0; stray_cnt = 0;
        acc_cyc = -1; enq_cyc = -1; last_deq_cyc = -1; err_cyc = -1; done_cyc = -1;
        last_enq_data = '0;
        got_data.delete();
        got_last.delete();
    endtask

    task automatic drive_inputs();
        bus.read_fifo_rdempty  = (rq.size() == 0);
        bus.read_fifo_data_out = (rq.size() != 0) ? rq[0] : '0;
        bus.req_fifo_wrfull    = (wrfull_cnt > 0);
        bus.rsp_ready          = (rdy_pat.size() != 0) ? rdy_pat[0] : rdy_default;
    endtask

    // Observe at negedge, apply FIFO effects just after the following posedge.
    task automatic tick();
        bit deq_s, enq_s, valid_s;
        logic [31:0] tmp;
        @(negedge clk);
        cyc++;
        deq_s   = bus.read_fifo_deq;
        enq_s   = bus.req_fifo_enq;
        valid_s = bus.rsp_valid;
        if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
        if (!bus.read_fifo_rdempty && bus.cmd_ready) rdy_bad++;
        if (enq_s) begin
            enq_cnt++;
            last_enq_data = bus.req_fifo_data_in;
            enq_cyc = cyc;
            if (bus.req_fifo_wrfull) enq_bad++;
        end
        if (deq_s && bus.busy && !(bus.rsp_valid && bus.rsp_ready)) deq_bad++;
        if (deq_s && !bus.busy) stray_cnt++;
        if (bus.rsp_valid && bus.rsp_ready) begin
            got_data.push_back(bus.rsp_data);
            got_last.push_back(bus.rsp_last);
            last_deq_cyc = cyc;
        end
        if (bus.done) begin done_cnt++; done_cyc = cyc; end
        if (bus.err)  begin err_cnt++;  err_cyc  = cyc; end
        if (bus.done && bus.err) both_cnt++;
        @(posedge clk);
        #1;
        if (deq_s && rq.size() != 0) tmp = rq.pop_front();
        if (enq_s) while (pending.size() != 0) rq.push_back(pending.pop_front());
        if (valid_s && rdy_pat.size() != 0) rdy_pat.pop_front();
        if (wrfull_cnt > 0) wrfull_cnt--;
        drive_inputs();
        #1;
    endtask

    task automatic send_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len);
        bit accepted = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        for (int i = 0; i < 20 && !accepted; i++) begin
            tick();
            accepted = (acc_cyc == cyc);
        end
        bus.cmd_valid = 1'b0;
        if (!accepted) check("cmd_accept_bound", 32'(accepted), 1);
    endtask

    task automatic run_until_event(input int budget);
        int start = done_cnt + err_cnt;
        int i = 0;
        while (done_cnt + err_cnt == start && i < budget) begin
            tick();
            i++;
        end
        if (done_cnt + err_cnt == start) check("event_bound", 0, 1);
    endtask

    function automatic logic [31:0] last_bits();
        logic [31:0] v = '0;
        foreach (got_last[i]) v[i] = got_last[i];
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        drive_inputs();
        tick();
        tick();
        rst = 1'b0;
        clear_stats();
        check("rst_busy",      32'(bus.busy), 0);
        check("rst_enq",       32'(bus.req_fifo_enq), 0);
        check("rst_done",      32'(bus.done), 0);
        check("rst_err",       32'(bus.err), 0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);

        // Basic read, len 4
        pending = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        send_cmd(24'h10, 8'd4);
        run_until_event(50);
        tick();
        check("basic_enq_cnt",  enq_cnt, 1);
        check("basic_enq_data", last_enq_data, 32'h0400_0010);
        check("basic_enq_lat",  enq_cyc - acc_cyc, 1);
        check("basic_rsp_cnt",  got_data.size(), 4);
        for (int i = 0; i < 4 && i < got_data.size(); i++)
            check($sformatf("basic_rsp%0d", i), got_data[i], 32'hA0 + i);
        check("basic_last",     last_bits(), 32'b1000);
        check("basic_done",     done_cnt, 1);
        check("basic_err",      err_cnt, 0);
        check("basic_busy",     32'(bus.busy), 0);

        // Consumer backpressure, len 3
        clear_stats();
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        pending = '{32'hB0, 32'hB1, 32'hB2};
        send_cmd(24'h200, 8'd3);
        run_until_event(50);
        check("bp_rsp_cnt", got_data.size(), 3);
        for (int i = 0; i < 3 && i < got_data.size(); i++)
            check($sformatf("bp_rsp%0d", i), got_data[i], 32'hB0 + i);
        check("bp_last",     last_bits(), 32'b100);
        check("bp_done",     done_cnt, 1);
        check("bp_done_lat", done_cyc - last_deq_cyc, 1);

        // Request FIFO full for 5 cycles after accept
        clear_stats();
        pending = '{32'hC0};
        send_cmd(24'h12_3456, 8'd1);
        wrfull_cnt = 5;
        drive_inputs();
        run_until_event(50);
        check("full_enq_cnt",  enq_cnt, 1);
        check("full_enq_lat",  enq_cyc - acc_cyc, 6);
        check("full_enq_data", last_enq_data, 32'h0112_3456);
        check("full_rsp",      (got_data.size() == 1) ? got_data[0] : 32'hDEAD, 32'hC0);
        check("full_last",     last_bits(), 32'b1);
        check("full_done",     done_cnt, 1);

        // Illegal lengths 0 and MAX_WORDS+1
        clear_stats();
        send_cmd(24'h5, 8'd0);
        tick();
        send_cmd(24'h5, 8'd9);
        tick();
        tick();
        check("ill_err",       err_cnt, 2);
        check("ill_enq",       enq_cnt, 0);
        check("ill_done",      done_cnt, 0);
        check("ill_busy",      32'(bus.busy), 0);
        check("ill_cmd_ready", 32'(bus.cmd_ready), 1);

        // Largest legal length
        clear_stats();
        for (int i = 0; i < MAXW; i++) pending.push_back(32'h100 + i);
        send_cmd(24'h20, 8'd8);
        run_until_event(50);
        check("max_enq_data", last_enq_data, 32'h0800_0020);
        check("max_rsp_cnt",  got_data.size(), 8);
        check("max_last",     last_bits(), 32'h80);
        check("max_done",     done_cnt, 1);
        check("max_err",      err_cnt, 0);

        // Timeout after one of two words, then a late stray word
        clear_stats();
        pending = '{32'hD0};
        send_cmd(24'h40, 8'd2);
        run_until_event(100);
        check("to_err",     err_cnt, 1);
        check("to_done",    done_cnt, 0);
        check("to_rsp_cnt", got_data.size(), 1);
        check("to_lat",     err_cyc - last_deq_cyc, TO + 1);
        check("to_busy",    32'(bus.busy), 0);
        rq.push_back(32'hD1);
        drive_inputs();
        #1;
        check("stray_cmd_ready", 32'(bus.cmd_ready), 0);
        tick();
        tick();
        check("stray_err",       err_cnt, 2);
        check("stray_deq",       stray_cnt, 1);
        check("stray_ready_out", 32'(bus.cmd_ready), 1);

        // Reset mid-COLLECT after 1 of 4 words
        clear_stats();
        rdy_default = 1'b0;
        rdy_pat = '{1'b1};
        pending = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
        send_cmd(24'h80, 8'd4);
        for (int i = 0; i < 20 && got_data.size() == 0; i++) tick();
        tick();
        check("mid_rsp_cnt", got_data.size(), 1);
        clear_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy",      32'(bus.busy), 0);
        check("mrst_enq",       32'(bus.req_fifo_enq), 0);
        check("mrst_done",      32'(bus.done), 0);
        check("mrst_err",       32'(bus.err), 0);
        check("mrst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("mrst_cmd_ready", 32'(bus.cmd_ready), 0);
        rdy_default = 1'b1;
        drive_inputs();
        pending = '{32'hF0};
        send_cmd(24'h99, 8'd1);
        run_until_event(50);
        check("mrst_stray_cnt", stray_cnt, 3);
        check("mrst_err_cnt",   err_cnt, 3);
        check("mrst_enq_data",  last_enq_data, 32'h0100_0099);
        check("mrst_rsp",       (got_data.size() == 1) ? got_data[0] : 32'hDEAD, 32'hF0);
        check("mrst_done",      done_cnt, 1);

        // Protocol invariants over the whole run
        check("deq_without_handshake",   deq_bad, 0);
        check("enq_while_full",          enq_bad, 0);
        check("done_err_overlap",        both_cnt, 0);
        check("cmd_ready_while_nonempty", rdy_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
